// File: rtl/uart_record_assembler.sv
// uart_record_assembler
// Hunts for a two-byte sync word in a UART byte stream. It then collects a
// 25-byte event payload and checks the trailing XOR checksum. Each good frame
// is emitted as a single-beat 256-bit AXI-Stream word.
//   clk, rst_n        : clock, synchronous active-low reset
//   s_axis_*          : 8-bit byte stream in (tdata/tvalid/tready)
//   m_axis_*          : 256-bit record out (tdata/tvalid/tready/tlast)
//   rec_count         : records delivered (wraps)
//   cksum_err_count   : checksum failures (saturating)
//   timeout_count     : inter-byte timeouts inside a frame (saturating)
module uart_record_assembler #(
  parameter logic [7:0]  SYNC0          = 8'hA5,
  parameter logic [7:0]  SYNC1          = 8'h5A,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [255:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic [31:0]  rec_count,
  output logic [15:0]  cksum_err_count,
  output logic [15:0]  timeout_count
);

  localparam int unsigned NUM_LANES = 25;
  localparam int unsigned IW        = 5;
  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {HUNT0, HUNT1, PAY, CHK, OUT} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [7:0]    xor_acc;
  logic [TW-1:0] tmo;
  logic          byte_acc;

  assign byte_acc = s_axis_tvalid && s_axis_tready;

  // Frame state machine, lane capture, timeout and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= HUNT0;
      idx             <= '0;
      xor_acc         <= '0;
      tmo             <= '0;
      s_axis_tready   <= 1'b0;
      m_axis_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      rec_count       <= '0;
      cksum_err_count <= '0;
      timeout_count   <= '0;
    end else begin
      // Inter-byte timeout; state changes below only happen on an accepted
      // byte, so an accepted byte always overrides an expiring timeout.
      if (state inside {HUNT1, PAY, CHK}) begin
        if (byte_acc) begin
          tmo <= '0;
        end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo   <= '0;
          state <= HUNT0;
          if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
        end else begin
          tmo <= tmo + TW'(1);
        end
      end

      case (state)
        HUNT0: begin
          s_axis_tready <= 1'b1;
          tmo           <= '0;
          if (byte_acc && s_axis_tdata == SYNC0) state <= HUNT1;
        end
        HUNT1: begin
          if (byte_acc) begin
            if (s_axis_tdata == SYNC1) begin
              state   <= PAY;
              idx     <= '0;
              xor_acc <= '0;
            end else if (s_axis_tdata != SYNC0) begin
              state <= HUNT0;
            end
          end
        end
        PAY: begin
          if (byte_acc) begin
            m_axis_tdata[8*idx +: 8] <= s_axis_tdata;
            xor_acc <= xor_acc ^ s_axis_tdata;
            idx     <= idx + IW'(1);
            if (idx == IW'(NUM_LANES - 1)) state <= CHK;
          end
        end
        CHK: begin
          if (byte_acc) begin
            if (s_axis_tdata == xor_acc) begin
              state         <= OUT;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= 1'b1;
              s_axis_tready <= 1'b0;
            end else begin
              state <= HUNT0;
              if (cksum_err_count != 16'hFFFF) cksum_err_count <= cksum_err_count + 16'd1;
            end
          end
        end
        OUT: begin
          // Record is held stable; no timeout while backpressured
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            s_axis_tready <= 1'b1;
            rec_count     <= rec_count + 32'd1;
            state         <= HUNT0;
          end
        end
        default: state <= HUNT0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_record_assembler.sv
// tb_uart_record_assembler
// Directed self-checking bench for uart_record_assembler (TIMEOUT_CYCLES=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_record_assembler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [31:0]  rec_count;
  logic [15:0]  cksum_err_count;
  logic [15:0]  timeout_count;

  int vecs = 0;
  int errs = 0;
  logic [7:0]   pay [25];
  logic [255:0] exp_word;

  uart_record_assembler #(
    .SYNC0(8'hA5), .SYNC1(8'h5A), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .rec_count(rec_count), .cksum_err_count(cksum_err_count),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one byte and hold it until accepted (bounded wait)
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_axis_tready) check("byte_accept_wait", 256'(s_axis_tready), 256'd1);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_body(input logic [7:0] ck_mask);
    logic [7:0] ck = 8'h00;
    for (int i = 0; i < 25; i++) begin
      send_byte(pay[i]);
      ck ^= pay[i];
    end
    send_byte(ck ^ ck_mask);
  endtask

  task automatic send_frame(input logic [7:0] ck_mask);
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_body(ck_mask);
  endtask

  task automatic build_exp();
    exp_word = '0;
    for (int i = 0; i < 25; i++) exp_word[8*i +: 8] = pay[i];
  endtask

  task automatic pay_ascending();
    for (int i = 0; i < 25; i++) pay[i] = 8'(i + 1);
  endtask

  // Expects a record presented right after the CK byte, with tready high
  task automatic expect_record(input string tag, input logic [31:0] count);
    build_exp();
    check({tag, "_tvalid"}, 256'(m_axis_tvalid), 256'd1);
    check({tag, "_tlast"},  256'(m_axis_tlast),  256'd1);
    check({tag, "_tdata"},  m_axis_tdata, exp_word);
    @(negedge clk);
    check({tag, "_tvalid_drop"}, 256'(m_axis_tvalid), 256'd0);
    check({tag, "_rec_count"},   256'(rec_count), 256'(count));
  endtask

  initial begin
    rst_n         = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 256'(s_axis_tready), 256'd0);
    check("rst_tvalid",  256'(m_axis_tvalid), 256'd0);
    check("rst_tlast",   256'(m_axis_tlast), 256'd0);
    check("rst_tdata",   m_axis_tdata, 256'd0);
    check("rst_counts",  256'({rec_count, cksum_err_count, timeout_count}), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_rst", 256'(s_axis_tready), 256'd1);

    // 1: good frame, payload 01..19, CK = 01
    pay_ascending();
    send_frame(8'h00);
    check("t1_lane0",  256'(m_axis_tdata[7:0]), 256'h01);
    check("t1_lane24", 256'(m_axis_tdata[199:192]), 256'h19);
    check("t1_upper",  256'(m_axis_tdata[255:200]), 256'd0);
    expect_record("t1", 32'd1);

    // 2: inverted checksum dropped, then good frame with sync bytes in payload
    send_frame(8'hFF);
    repeat (2) @(negedge clk);
    check("t2_no_beat", 256'(m_axis_tvalid), 256'd0);
    check("t2_cksum_err", 256'(cksum_err_count), 256'd1);
    for (int i = 0; i < 25; i++) pay[i] = 8'(i * 37 + 11);
    pay[0] = 8'hA5;
    pay[1] = 8'h5A;
    send_frame(8'h00);
    expect_record("t2", 32'd2);

    // 3: resync through 00 A5 A5 5A; then A5 33 5A + body must be dropped
    pay_ascending();
    send_byte(8'h00);
    send_byte(8'hA5);
    send_frame(8'h00);
    expect_record("t3a", 32'd3);
    send_byte(8'hA5);
    send_byte(8'h33);
    send_byte(8'h5A);
    send_body(8'h00);
    repeat (3) @(negedge clk);
    check("t3b_no_beat",  256'(m_axis_tvalid), 256'd0);
    check("t3b_rec_count", 256'(rec_count), 256'd3);
    check("t3b_cksum_err", 256'(cksum_err_count), 256'd1);

    // 4: backpressure for 50 clocks
    m_axis_tready = 1'b0;
    for (int i = 0; i < 25; i++) pay[i] = 8'(8'hF0 - 8'(i * 3));
    build_exp();
    send_frame(8'h00);
    for (int i = 0; i < 50; i++) begin
      check("t4_s_ready_low", 256'(s_axis_tready), 256'd0);
      check("t4_tvalid_held", 256'(m_axis_tvalid), 256'd1);
      check("t4_tdata_stable", m_axis_tdata, exp_word);
      @(negedge clk);
    end
    check("t4_rec_count_held", 256'(rec_count), 256'd3);
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("t4_tvalid_drop", 256'(m_axis_tvalid), 256'd0);
    check("t4_s_ready_back", 256'(s_axis_tready), 256'd1);
    check("t4_rec_count", 256'(rec_count), 256'd4);

    // 5: timeout after 10 payload bytes, then recovery
    pay_ascending();
    send_byte(8'hA5);
    send_byte(8'h5A);
    for (int i = 0; i < 10; i++) send_byte(pay[i]);
    repeat (20) @(negedge clk);
    check("t5_timeout_count", 256'(timeout_count), 256'd1);
    check("t5_no_beat", 256'(m_axis_tvalid), 256'd0);
    send_frame(8'h00);
    expect_record("t5", 32'd5);
    check("t5_timeout_once", 256'(timeout_count), 256'd1);

    // 6: reset mid-frame after 12 payload bytes
    send_byte(8'hA5);
    send_byte(8'h5A);
    for (int i = 0; i < 12; i++) send_byte(pay[i]);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_s_ready", 256'(s_axis_tready), 256'd0);
    check("t6_tvalid",  256'(m_axis_tvalid), 256'd0);
    check("t6_tdata",   m_axis_tdata, 256'd0);
    check("t6_counts",  256'({rec_count, cksum_err_count, timeout_count}), 256'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) pay[i] = 8'(8'h80 + 8'(i));
    send_frame(8'h00);
    expect_record("t6", 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
